// File: rtl/avl_gain_master.sv
// avl_gain_master
// Avalon-MM master that streams len 32-bit words from src to dst, scaling
// each word by an unsigned Q8.8 gain. One word = one read followed by one
// write; no outstanding transactions.
//
// Build option: define AVM_GAIN_SAT_EN to saturate the scaled result to the
// signed 32-bit range; otherwise the result wraps (product bits [39:8]).
//
// Ports
//   csi_clk              system clock, rising edge
//   rsi_reset            synchronous active-high reset
//   ctl_start            start pulse, only sampled in IDLE
//   ctl_src / ctl_dst    word-aligned source / destination byte addresses
//   ctl_len              number of words to move
//   ctl_gain             unsigned Q8.8 gain (0x0100 = 1.0)
//   ctl_busy             high while a transfer is in flight
//   ctl_done             one-cycle completion pulse
//   ctl_count            words written in the current or last transfer
//   avm_m0_*             Avalon-MM master port
//
// state | meaning
// IDLE  | waiting for ctl_start
// RD    | read request held until waitrequest drops
// WR    | write of the scaled sample held until waitrequest drops
// DONE  | one-cycle completion pulse, then back to IDLE
module avl_gain_master #(
    parameter int LEN_W = 16
) (
    input  logic             csi_clk,
    input  logic             rsi_reset,
    input  logic             ctl_start,
    input  logic [31:0]      ctl_src,
    input  logic [31:0]      ctl_dst,
    input  logic [LEN_W-1:0] ctl_len,
    input  logic [15:0]      ctl_gain,
    output logic             ctl_busy,
    output logic             ctl_done,
    output logic [LEN_W-1:0] ctl_count,
    output logic [31:0]      avm_m0_address,
    output logic             avm_m0_read,
    output logic             avm_m0_write,
    output logic [31:0]      avm_m0_writedata,
    output logic [3:0]       avm_m0_byteenable,
    input  logic [31:0]      avm_m0_readdata,
    input  logic             avm_m0_waitrequest
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state_q, state_n;
    logic [31:0]        src_q, src_n;
    logic [31:0]        dst_q, dst_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [15:0]        gain_q, gain_n;
    logic [LEN_W-1:0]   count_q, count_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               read_q, read_n;
    logic               write_q, write_n;
    logic [31:0]        addr_q, addr_n;
    logic [31:0]        wdata_q, wdata_n;

    logic signed [47:0] sample_ext;
    logic signed [47:0] gain_ext;
    logic signed [47:0] product;
    logic [31:0]        result;
    logic [LEN_W-1:0]   count_inc;

    assign avm_m0_byteenable = 4'b1111;

    // 32x17-bit signed product always fits in 48 bits, so no overflow here.
    assign sample_ext = {{16{avm_m0_readdata[31]}}, avm_m0_readdata};
    assign gain_ext   = {32'd0, gain_q};
    assign product    = sample_ext * gain_ext;

`ifdef AVM_GAIN_SAT_EN
    // The shifted value fits in 32 signed bits only if bits [47:39] agree.
    always_comb begin
        if ((product[47:39] == 9'h000) || (product[47:39] == 9'h1FF)) begin
            result = product[39:8];
        end else if (product[47]) begin
            result = 32'h8000_0000;
        end else begin
            result = 32'h7FFF_FFFF;
        end
    end
`else
    assign result = product[39:8];
`endif

    assign count_inc = count_q + LEN_W'(1);

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            gain_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_n;
            src_q   <= src_n;
            dst_q   <= dst_n;
            len_q   <= len_n;
            gain_q  <= gain_n;
            count_q <= count_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            read_q  <= read_n;
            write_q <= write_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
        end
    end

    always_comb begin
        state_n = state_q;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        gain_n  = gain_q;
        count_n = count_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        read_n  = read_q;
        write_n = write_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;

        case (state_q)
            IDLE: begin
                if (ctl_start) begin
                    src_n   = ctl_src;
                    dst_n   = ctl_dst;
                    len_n   = ctl_len;
                    gain_n  = ctl_gain;
                    count_n = '0;
                    if (ctl_len != '0) begin
                        read_n  = 1'b1;
                        addr_n  = ctl_src;
                        busy_n  = 1'b1;
                        state_n = RD;
                    end else begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            RD: begin
                if (!avm_m0_waitrequest) begin
                    wdata_n = result;
                    read_n  = 1'b0;
                    write_n = 1'b1;
                    addr_n  = dst_q;
                    state_n = WR;
                end
            end
            WR: begin
                if (!avm_m0_waitrequest) begin
                    write_n = 1'b0;
                    src_n   = src_q + 32'd4;
                    dst_n   = dst_q + 32'd4;
                    count_n = count_inc;
                    if (count_inc == len_q) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        read_n  = 1'b1;
                        addr_n  = src_q + 32'd4;
                        state_n = RD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ctl_busy         = busy_q;
    assign ctl_done         = done_q;
    assign ctl_count        = count_q;
    assign avm_m0_address   = addr_q;
    assign avm_m0_read      = read_q;
    assign avm_m0_write     = write_q;
    assign avm_m0_writedata = wdata_q;

endmodule

// File: tb/tb_avl_gain_master.sv
module tb_avl_gain_master;

    localparam int LEN_W = 16;

    logic             csi_clk = 1'b0;
    logic             rsi_reset;
    logic             ctl_start;
    logic [31:0]      ctl_src;
    logic [31:0]      ctl_dst;
    logic [LEN_W-1:0] ctl_len;
    logic [15:0]      ctl_gain;
    logic             ctl_busy;
    logic             ctl_done;
    logic [LEN_W-1:0] ctl_count;
    logic [31:0]      avm_m0_address;
    logic             avm_m0_read;
    logic             avm_m0_write;
    logic [31:0]      avm_m0_writedata;
    logic [3:0]       avm_m0_byteenable;
    logic [31:0]      avm_m0_readdata;
    logic             avm_m0_waitrequest;

    avl_gain_master #(.LEN_W(LEN_W)) dut (
        .csi_clk            (csi_clk),
        .rsi_reset          (rsi_reset),
        .ctl_start          (ctl_start),
        .ctl_src            (ctl_src),
        .ctl_dst            (ctl_dst),
        .ctl_len            (ctl_len),
        .ctl_gain           (ctl_gain),
        .ctl_busy           (ctl_busy),
        .ctl_done           (ctl_done),
        .ctl_count          (ctl_count),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_read        (avm_m0_read),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_byteenable  (avm_m0_byteenable),
        .avm_m0_readdata    (avm_m0_readdata),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    always #5 csi_clk = ~csi_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] slave_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] samples[$];

    int          stall_n = 0;
    int          stall_cnt = 0;
    int          wr_accepts = 0;
    int          bus_cycles = 0;
    int          done_pulses = 0;
    logic [31:0] last_wd = '0;
    logic [31:0] last_ra = '0;

    logic        p_act = 1'b0, p_wait = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference scaling: floor(sample * gain / 256), then clamp or wrap.
    function automatic logic [31:0] model_gain(input logic [31:0] s, input logic [15:0] g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
        p = p >>> 8;
`ifdef AVM_GAIN_SAT_EN
        if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
        return p[31:0];
    endfunction

    // Slave: stalls each request stall_n cycles, then accepts it.
    always @(posedge csi_clk) begin
        #1;
        if (avm_m0_read || avm_m0_write) begin
            if (stall_cnt < stall_n) begin
                avm_m0_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                avm_m0_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end else begin
            avm_m0_waitrequest = 1'b0;
            stall_cnt = 0;
        end
        avm_m0_readdata = (avm_m0_read && slave_q.size() > 0) ? slave_q[0] : 32'hDEAD_BEEF;
    end

    // Per-cycle compare against the expected transaction queues.
    always @(negedge csi_clk) begin
        if (!rsi_reset) begin
            chk("rd_wr_excl", {31'd0, avm_m0_read & avm_m0_write}, 32'd0);
            chk("byteenable", {28'd0, avm_m0_byteenable}, 32'hF);
            if ((avm_m0_read || avm_m0_write) && p_act && p_wait) begin
                chk("stall_read",  {31'd0, avm_m0_read},  {31'd0, p_rd});
                chk("stall_write", {31'd0, avm_m0_write}, {31'd0, p_wr});
                chk("stall_addr",  avm_m0_address, p_addr);
                if (avm_m0_write) chk("stall_wdata", avm_m0_writedata, p_wd);
            end
            if (avm_m0_read || avm_m0_write) bus_cycles++;
            if (avm_m0_read && !avm_m0_waitrequest) begin
                last_ra = avm_m0_address;
                if (exp_rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
                else chk("rd_addr", avm_m0_address, exp_rd_q.pop_front());
                if (slave_q.size() > 0) void'(slave_q.pop_front());
            end
            if (avm_m0_write && !avm_m0_waitrequest) begin
                last_wd = avm_m0_writedata;
                wr_accepts++;
                if (exp_wa_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    chk("wr_addr", avm_m0_address, exp_wa_q.pop_front());
                    chk("wr_data", avm_m0_writedata, exp_wd_q.pop_front());
                end
            end
            if (ctl_done) begin
                done_pulses++;
                chk("busy_in_done", {31'd0, ctl_busy}, 32'd0);
            end
        end
        p_act  = avm_m0_read || avm_m0_write;
        p_wait = avm_m0_waitrequest;
        p_rd   = avm_m0_read;
        p_wr   = avm_m0_write;
        p_addr = avm_m0_address;
        p_wd   = avm_m0_writedata;
    end

    task automatic issue_start(input logic [31:0] src, input logic [31:0] dst,
                               input logic [LEN_W-1:0] len, input logic [15:0] gain);
        @(negedge csi_clk);
        ctl_src   = src;
        ctl_dst   = dst;
        ctl_len   = len;
        ctl_gain  = gain;
        ctl_start = 1'b1;
        @(posedge csi_clk);
        #1;
        ctl_start = 1'b0;
        if (len != '0) begin
            chk("start_read", {31'd0, avm_m0_read}, 32'd1);
            chk("start_busy", {31'd0, ctl_busy}, 32'd1);
            chk("start_addr", avm_m0_address, src);
        end else begin
            chk("len0_read", {31'd0, avm_m0_read}, 32'd0);
            chk("len0_busy", {31'd0, ctl_busy}, 32'd0);
        end
        chk("start_count", 32'(ctl_count), 32'd0);
    endtask

    task automatic run_xfer(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input logic [LEN_W-1:0] len, input logic [15:0] gain,
                            input int stall, input bit poke);
        bit seen;
        stall_n     = stall;
        bus_cycles  = 0;
        done_pulses = 0;
        wr_accepts  = 0;
        for (int i = 0; i < int'(len); i++) begin
            slave_q.push_back(samples[i]);
            exp_rd_q.push_back(src + 32'(4 * i));
            exp_wa_q.push_back(dst + 32'(4 * i));
            exp_wd_q.push_back(model_gain(samples[i], gain));
        end
        issue_start(src, dst, len, gain);
        if (poke) begin
            @(negedge csi_clk);
            ctl_start = 1'b1;
            ctl_src   = 32'h0000_5000;
            ctl_dst   = 32'h0000_6000;
            ctl_len   = 7;
            ctl_gain  = 16'h0200;
            @(negedge csi_clk);
            ctl_start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (ctl_done) seen = 1'b1;
            else @(negedge csi_clk);
        end
        chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({name, "_count"}, 32'(ctl_count), 32'(len));
        @(negedge csi_clk);
        chk({name, "_done_once"}, 32'(done_pulses), 32'd1);
        chk({name, "_done_low"}, {31'd0, ctl_done}, 32'd0);
        chk({name, "_all_writes"}, 32'(exp_wd_q.size()), 32'd0);
        samples.delete();
    endtask

    initial begin
        bit found;
        rsi_reset          = 1'b1;
        ctl_start          = 1'b0;
        ctl_src            = '0;
        ctl_dst            = '0;
        ctl_len            = '0;
        ctl_gain           = '0;
        avm_m0_readdata    = '0;
        avm_m0_waitrequest = 1'b0;
        repeat (3) @(posedge csi_clk);
        #1;
        rsi_reset = 1'b0;
        chk("rst_read",  {31'd0, avm_m0_read},  32'd0);
        chk("rst_write", {31'd0, avm_m0_write}, 32'd0);
        chk("rst_busy",  {31'd0, ctl_busy},     32'd0);
        chk("rst_done",  {31'd0, ctl_done},     32'd0);
        chk("rst_count", 32'(ctl_count),        32'd0);
        chk("rst_addr",  avm_m0_address,        32'd0);
        chk("rst_wdata", avm_m0_writedata,      32'd0);
        chk("rst_be",    {28'd0, avm_m0_byteenable}, 32'hF);

        // zero-wait unity-gain copy
        samples = '{32'd5, 32'hFFFF_FFF9, 32'h1234_5678};
        run_xfer("copy", 32'h100, 32'h200, 3, 16'h0100, 0, 1'b0);
        chk("copy_bus_cycles", 32'(bus_cycles), 32'd6);
        chk("copy_last_data", last_wd, 32'h1234_5678);

        // stalled transfer, gain 1.5
        samples = '{32'd100, 32'hFFFF_FF9C};
        run_xfer("stall", 32'h1000, 32'h2000, 2, 16'h0180, 4, 1'b0);
        chk("stall_bus_cycles", 32'(bus_cycles), 32'd20);
        chk("stall_last_data", last_wd, 32'hFFFF_FF6A);

        // overflow: saturates or wraps depending on build
        samples = '{32'h4000_0000};
        run_xfer("ovf", 32'h400, 32'h500, 1, 16'h0400, 0, 1'b0);
`ifdef AVM_GAIN_SAT_EN
        chk("ovf_data", last_wd, 32'h7FFF_FFFF);
`else
        chk("ovf_data", last_wd, 32'h0000_0000);
`endif

        // negative sample rounds toward minus infinity
        samples = '{32'hFFFF_FFFD};
        run_xfer("neg", 32'h600, 32'h700, 1, 16'h0080, 1, 1'b0);
        chk("neg_data", last_wd, 32'hFFFF_FFFE);

        // len = 0
        bus_cycles = 0;
        issue_start(32'h800, 32'h900, 0, 16'h0100);
        @(negedge csi_clk);
        chk("len0_done",  {31'd0, ctl_done},     32'd1);
        chk("len0_rd",    {31'd0, avm_m0_read},  32'd0);
        chk("len0_wr",    {31'd0, avm_m0_write}, 32'd0);
        chk("len0_count", 32'(ctl_count),        32'd0);
        @(negedge csi_clk);
        chk("len0_done_low", {31'd0, ctl_done}, 32'd0);
        chk("len0_bus",      32'(bus_cycles),   32'd0);

        // reset during the second, stalled write
        samples = '{32'd1, 32'd2, 32'd3};
        stall_n    = 4;
        wr_accepts = 0;
        for (int i = 0; i < 3; i++) begin
            slave_q.push_back(samples[i]);
            exp_rd_q.push_back(32'hA00 + 32'(4 * i));
            exp_wa_q.push_back(32'hB00 + 32'(4 * i));
            exp_wd_q.push_back(model_gain(samples[i], 16'h0100));
        end
        samples.delete();
        issue_start(32'hA00, 32'hB00, 3, 16'h0100);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge csi_clk);
            if (avm_m0_write && avm_m0_waitrequest && wr_accepts == 1) found = 1'b1;
        end
        chk("rst_wr_found", {31'd0, found}, 32'd1);
        rsi_reset = 1'b1;
        @(posedge csi_clk);
        #1;
        rsi_reset = 1'b0;
        chk("abort_write", {31'd0, avm_m0_write}, 32'd0);
        chk("abort_read",  {31'd0, avm_m0_read},  32'd0);
        chk("abort_busy",  {31'd0, ctl_busy},     32'd0);
        chk("abort_count", 32'(ctl_count),        32'd0);
        slave_q.delete();
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        repeat (2) @(negedge csi_clk);
        chk("abort_idle_rd", {31'd0, avm_m0_read}, 32'd0);

        samples = '{32'h0000_0010, 32'h0000_0020};
        run_xfer("restart", 32'hC00, 32'hD00, 2, 16'h0200, 0, 1'b0);
        chk("restart_data", last_wd, 32'h0000_0040);

        // address wrap with an ignored start mid-transfer
        samples = '{32'h0000_0AAA, 32'h0000_0BBB};
        run_xfer("wrap", 32'hFFFF_FFFC, 32'h300, 2, 16'h0100, 0, 1'b1);
        chk("wrap_last_raddr", last_ra, 32'h0000_0000);
        chk("wrap_last_data",  last_wd, 32'h0000_0BBB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avl_gain_master.md
AVL_GAIN_MASTER -- requirements
Module: avl_gain_master

Interface
REQ-001 The block SHALL have one clock, csi_clk; reset rsi_reset SHALL be synchronous and active-high.
REQ-002 Parameter: LEN_W, 16, width of transfer length and count.
REQ-003 Port: csi_clk  in  1  system clock, all logic rising-edge.
REQ-004 Port: rsi_reset  in  1  synchronous active-high reset.
REQ-005 Port: ctl_start  in  1  start pulse, sampled only in IDLE.
REQ-006 Port: ctl_src  in  32  source byte address, word-aligned.
REQ-007 Port: ctl_dst  in  32  destination byte address, word-aligned.
REQ-008 Port: ctl_len  in  LEN_W  number of 32-bit words to process.
REQ-009 Port: ctl_gain  in  16  unsigned gain, Q8.8 (0x0100 = 1.0).
REQ-010 Port: ctl_busy  out  1  high from the cycle after an accepted start until DONE is reached.
REQ-011 Port: ctl_done  out  1  one-cycle completion pulse.
REQ-012 Port: ctl_count  out  LEN_W  words fully written in the current or last transfer.
REQ-013 Port: avm_m0_address  out  32  Avalon-MM master byte address.
REQ-014 Port: avm_m0_read  out  1  read request.
REQ-015 Port: avm_m0_write  out  1  write request.
REQ-016 Port: avm_m0_writedata  out  32  write data.
REQ-017 Port: avm_m0_byteenable  out  4  constant 4'b1111.
REQ-018 Port: avm_m0_readdata  in  32  read data, valid in the cycle where read=1 and waitrequest=0.
REQ-019 Port: avm_m0_waitrequest  in  1  slave stall.

Function
REQ-020 The FSM states SHALL be IDLE, RD, WR and DONE; all outputs SHALL be registered.
REQ-021 In IDLE with ctl_start=1 and ctl_len!=0, the block SHALL latch src, dst, len and gain, clear ctl_count, and enter RD, with avm_m0_read=1 in the next cycle.
REQ-022 In IDLE with ctl_start=1 and ctl_len=0, the block SHALL go directly to DONE with no bus activity.
REQ-023 ctl_start SHALL be ignored in RD, WR and DONE; latched parameters SHALL NOT change mid-transfer.
REQ-024 In RD, read=1 and address=src_ptr SHALL be held stable until waitrequest=0; in that cycle readdata is captured and the state moves to WR.
REQ-025 In WR, write=1, address=dst_ptr and writedata=processed sample SHALL be held stable until waitrequest=0.
REQ-026 When a write is accepted, src_ptr and dst_ptr SHALL each advance by 4 modulo 2^32 and ctl_count SHALL increment.
REQ-027 After the accepted write, the block SHALL go to DONE if the new count equals len, else to RD.
REQ-028 read and write SHALL never be asserted together.
REQ-029 Each word SHALL cost at least 2 cycles: one for read, one for write.
REQ-030 In DONE, ctl_done=1 and ctl_busy=0 for exactly one cycle, then the state SHALL return to IDLE.
REQ-031 Processing: sample = readdata as signed 32-bit; product = sample x gain as a 48-bit signed value; result = product arithmetic-shifted right by 8 (rounds toward minus infinity).
REQ-032 Address wrap-around past 0xFFFFFFFC SHALL continue at 0x00000000 with no error.

Reset
REQ-033 On rsi_reset=1 at a clock edge, the state SHALL become IDLE.
REQ-034 On reset, read, write, ctl_busy, ctl_done, ctl_count, address and writedata SHALL be 0; byteenable SHALL stay 4'b1111.
REQ-035 Reset during RD or WR SHALL abort the transfer and drop read/write at that edge; no resume.

Configuration
REQ-036 With AVM_GAIN_SAT_EN defined, the result SHALL saturate to [0x80000000, 0x7FFFFFFF].
REQ-037 Without AVM_GAIN_SAT_EN, the result SHALL be bits [39:8] of the product (wraps).

Verification
REQ-038 Zero-wait copy: src=0x100, dst=0x200, len=3, gain=0x0100, readdata 5,-7,0x12345678 -> writes to 0x200/0x204/0x208 of the same values; done pulses once; count=3; 6 bus cycles.
REQ-039 Stall: waitrequest=1 for 4 cycles on each read and write -> address, read/write and writedata stay stable; data correct.
REQ-040 Gain and saturation: readdata 0x40000000, gain 0x0400 -> 0x7FFFFFFF with AVM_GAIN_SAT_EN, 0x00000000 without; readdata -3, gain 0x0080 -> 0xFFFFFFFE.
REQ-041 len=0 start -> done pulses one cycle later; no read or write asserted; count=0.
REQ-042 Reset asserted in the 2nd WR while stalled -> next cycle write=0, busy=0, count=0, state IDLE; a new start works normally.
REQ-043 Start pulsed while busy, and src=0xFFFFFFFC with len=2 -> second start ignored; reads at 0xFFFFFFFC then 0x00000000.
